// File: rtl/seq_player_pkg.sv
// seq_player_pkg: shared game widths and playback FSM state encoding
package seq_player_pkg;
  localparam int SYM_W_DEF   = 4;
  localparam int ROUND_W_DEF = 4;
  localparam int BLANK_SYM   = 0;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_t;
endpackage

// File: rtl/seq_player_dwell.sv
// dwell_counter: tick-gated dwell counter with clear and terminal-count compare
module dwell_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign tc = cnt_q == term;
endmodule

// File: rtl/seq_player.sv
// seq_player: replays the stored symbol sequence on the LEDs, then raises end_fpga
module seq_player
  import seq_player_pkg::*;
#(
  parameter int SYM_W     = SYM_W_DEF,
  parameter int ROUND_W   = ROUND_W_DEF,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 1,
  parameter int TICK_W    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic [ROUND_W-1:0] round,
  input  logic               tick,
  output logic [ROUND_W-1:0] rom_addr,
  input  logic [SYM_W-1:0]   rom_data,
  output logic [SYM_W-1:0]   leds,
  output logic               busy,
  output logic               end_fpga
);
  state_t             state_q, state_d;
  logic               en_q;
  logic [ROUND_W-1:0] idx_q, idx_d, last_q, last_d;
  logic [SYM_W-1:0]   leds_q, leds_d;
  logic               start, dwell, tc, step, active;
  assign start  = en & ~en_q;
  assign dwell  = state_q == S_SHOW || state_q == S_GAP;
  assign active = state_q == S_FETCH || state_q == S_LOAD || dwell;
  assign step   = tick & tc;
  // Counter is held clear outside SHOW/GAP and restarts at each dwell boundary
  dwell_counter #(.W(TICK_W)) u_dwell (
    .clock (clock),
    .reset (reset),
    .clr   (~dwell | step),
    .inc   (tick),
    .term  (state_q == S_SHOW ? TICK_W'(ON_TICKS - 1) : TICK_W'(OFF_TICKS - 1)),
    .tc    (tc)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    leds_d  = leds_q;
    case (state_q)
      S_IDLE: begin
        leds_d = '0;
        if (start) begin
          idx_d   = '0;
          last_d  = round;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        leds_d  = rom_data;
        state_d = S_SHOW;
      end
      S_SHOW:
        if (step) begin
          leds_d  = '0;
          state_d = S_GAP;
        end
      S_GAP:
        if (step) begin
          // compare before increment so idx never wraps at the max round
          if (idx_q == last_q) state_d = S_DONE;
          else begin
            idx_d   = idx_q + ROUND_W'(1);
            state_d = S_FETCH;
          end
        end
      S_DONE: if (!en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!en && active) begin
      state_d = S_IDLE;
      leds_d  = '0;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      idx_q   <= '0;
      last_q  <= '0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en;
      idx_q   <= idx_d;
      last_q  <= last_d;
      leds_q  <= leds_d;
    end
  assign rom_addr = idx_q;
  assign leds     = leds_q;
  assign busy     = active;
  assign end_fpga = state_q == S_DONE;
endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: directed scenario checks for the playback sequencer
module tb_seq_player;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [3:0] round = '0;
  logic       tick = 1'b0;
  logic [3:0] rom_addr;
  logic [3:0] rom_data = '0;
  logic [3:0] leds;
  logic       busy;
  logic       end_fpga;
  logic [3:0] rom [16];
  int tests = 0;
  int fails = 0;

  seq_player dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .round    (round),
    .tick     (tick),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .leds     (leds),
    .busy     (busy),
    .end_fpga (end_fpga)
  );

  always #5 clock = ~clock;
  always @(posedge clock) rom_data <= rom[rom_addr];

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (leds !== 4'b0000 || rom_addr !== 4'd0 || busy !== 1'b0 || end_fpga !== 1'b0) begin
      fails++;
      $display("FAIL reset leds=%b addr=%0d busy=%b end=%b exp 0000/0/0/0", leds, rom_addr, busy, end_fpga);
    end
    reset = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic test_playback(input int r);
    int n;
    logic [3:0] el, ea;
    n = 5 * (r + 1);
    round = 4'(r);
    tick = 1'b1;
    en = 1'b1;
    for (int k = 0; k <= n + 2; k++) begin
      cyc();
      el = (k < n && (k % 5 == 2 || k % 5 == 3)) ? rom[k / 5] : 4'b0000;
      ea = k < n ? 4'(k / 5) : 4'(r);
      tests++;
      if (leds !== el) begin
        fails++;
        $display("FAIL play%0d_leds k=%0d got %b exp %b", r, k, leds, el);
      end
      tests++;
      if (rom_addr !== ea) begin
        fails++;
        $display("FAIL play%0d_addr k=%0d got %0d exp %0d", r, k, rom_addr, ea);
      end
      tests++;
      if (end_fpga !== (k >= n) || busy !== (k < n)) begin
        fails++;
        $display("FAIL play%0d_flags k=%0d end=%b busy=%b exp end=%b busy=%b", r, k, end_fpga, busy, k >= n, k < n);
      end
    end
    en = 1'b0;
    cyc();
    tests++;
    if (end_fpga !== 1'b0 || busy !== 1'b0 || leds !== 4'b0000) begin
      fails++;
      $display("FAIL play%0d_release end=%b busy=%b leds=%b exp 0/0/0000", r, end_fpga, busy, leds);
    end
  endtask

  task automatic test_abort();
    rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100;
    round = 4'd2;
    tick = 1'b1;
    en = 1'b1;
    for (int k = 0; k <= 7; k++) cyc();
    tests++;
    if (leds !== 4'b0010) begin
      fails++;
      $display("FAIL abort_show got %b exp 0010", leds);
    end
    en = 1'b0;
    cyc();
    tests++;
    if (leds !== 4'b0000 || busy !== 1'b0 || end_fpga !== 1'b0) begin
      fails++;
      $display("FAIL abort_edge leds=%b busy=%b end=%b exp 0000/0/0", leds, busy, end_fpga);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      tests++;
      if (end_fpga !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL abort_idle k=%0d end=%b busy=%b exp 0/0", k, end_fpga, busy);
      end
    end
    en = 1'b1;
    cyc();
    tests++;
    if (rom_addr !== 4'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_restart addr=%0d busy=%b exp 0/1", rom_addr, busy);
    end
    en = 1'b0;
    cyc();
  endtask

  task automatic test_slow_tick();
    int lit0, lit1, k_clear0, k_addr1, end_k;
    lit0 = 0; lit1 = 0; k_clear0 = -1; k_addr1 = -1; end_k = -1;
    rom[0] = 4'b0100; rom[1] = 4'b1000;
    round = 4'd1;
    en = 1'b1;
    for (int k = 0; k < 80; k++) begin
      tick = (k % 10 == 2);
      cyc();
      if (leds === rom[0]) lit0++;
      if (leds === rom[1]) lit1++;
      if (lit0 > 0 && leds === 4'b0000 && k_clear0 < 0) k_clear0 = k;
      if (rom_addr === 4'd1 && k_addr1 < 0) k_addr1 = k;
      if (end_fpga === 1'b1 && end_k < 0) end_k = k;
      if (k == 20) round = 4'd5;
    end
    tick = 1'b0;
    tests++;
    if (lit0 != 20) begin
      fails++;
      $display("FAIL slow_lit0 got %0d exp 20", lit0);
    end
    tests++;
    if (k_addr1 - k_clear0 != 10) begin
      fails++;
      $display("FAIL slow_gap got %0d exp 10", k_addr1 - k_clear0);
    end
    tests++;
    if (lit1 != 18) begin
      fails++;
      $display("FAIL slow_lit1 got %0d exp 18", lit1);
    end
    tests++;
    if (end_k != 62 || rom_addr !== 4'd1) begin
      fails++;
      $display("FAIL slow_done end_k=%0d addr=%0d exp 62/1", end_k, rom_addr);
    end
    en = 1'b0;
    cyc();
  endtask

  task automatic test_async_reset();
    rom[0] = 4'b0010;
    round = 4'd0;
    tick = 1'b1;
    en = 1'b1;
    cyc(); cyc(); cyc();
    tests++;
    if (leds !== 4'b0010) begin
      fails++;
      $display("FAIL areset_pre got %b exp 0010", leds);
    end
    #3 reset = 1'b0;
    #1;
    tests++;
    if (leds !== 4'b0000 || end_fpga !== 1'b0 || busy !== 1'b0 || rom_addr !== 4'd0) begin
      fails++;
      $display("FAIL areset_mid leds=%b end=%b busy=%b addr=%0d exp 0000/0/0/0", leds, end_fpga, busy, rom_addr);
    end
    en = 1'b0;
    #1 reset = 1'b1;
    cyc();
    tests++;
    if (leds !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL areset_post leds=%b busy=%b exp 0000/0", leds, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'b0001 << (i % 4);
    test_reset();
    rom[0] = 4'b0010;
    test_playback(0);
    rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100;
    test_playback(2);
    test_abort();
    test_slow_tick();
    test_async_reset();
    for (int i = 0; i < 16; i++) rom[i] = 4'b0001 << ((i + 1) % 4);
    test_playback(15);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
